// File: rtl/mc_controller_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit.
package mc_controller_pkg;

    typedef logic        u1;
    typedef logic [1:0]  u2;
    typedef logic [2:0]  u3;
    typedef logic [3:0]  u4;
    typedef logic [5:0]  u6;
    typedef logic [31:0] u32;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        IMMEX   = 4'd8,
        IMMWB   = 4'd9,
        BRANCH  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    localparam u6 OP_RTYPE = 6'b000000;
    localparam u6 OP_LW    = 6'b100011;
    localparam u6 OP_SW    = 6'b101011;
    localparam u6 OP_BEQ   = 6'b000100;
    localparam u6 OP_BNE   = 6'b000101;
    localparam u6 OP_ADDI  = 6'b001000;
    localparam u6 OP_SLTI  = 6'b001010;
    localparam u6 OP_J     = 6'b000010;

    localparam u6 F_ADD = 6'b100000;
    localparam u6 F_SUB = 6'b100010;
    localparam u6 F_AND = 6'b100100;
    localparam u6 F_OR  = 6'b100101;
    localparam u6 F_SLT = 6'b101010;

    localparam u3 ALU_ADD = 3'b010;
    localparam u3 ALU_SUB = 3'b110;
    localparam u3 ALU_AND = 3'b000;
    localparam u3 ALU_OR  = 3'b001;
    localparam u3 ALU_SLT = 3'b111;

endpackage

// File: rtl/mc_controller_if.sv
// Control bus between the controller (master) and the multicycle datapath (slave).
interface mc_controller_if
    import mc_controller_pkg::*;
#(
    parameter int unsigned CNT_W = 32
);
    u6              op;
    u6              funct;
    u1              zero;
    u1              pcen;
    u1              memwrite;
    u1              irwrite;
    u1              regwrite;
    u1              iord;
    u1              alusrca;
    u2              alusrcb;
    u1              memtoreg;
    u1              regdst;
    u2              pcsrc;
    u3              alucont;
    u1              illegal;
    u4              state_o;
    logic [CNT_W-1:0] instret;

    modport master (
        input  op, funct, zero,
        output pcen, memwrite, irwrite, regwrite, iord, alusrca, alusrcb,
               memtoreg, regdst, pcsrc, alucont, illegal, state_o, instret
    );

    modport slave (
        output op, funct, zero,
        input  pcen, memwrite, irwrite, regwrite, iord, alusrca, alusrcb,
               memtoreg, regdst, pcsrc, alucont, illegal, state_o, instret
    );
endinterface

// File: rtl/mc_controller_aludec.sv
// R-type funct decoder: ALU operation plus a flag for supported funct codes.
module mc_aludec
    import mc_controller_pkg::*;
(
    input  u6 funct,
    output u3 alucont,
    output u1 funct_ok
);
    always_comb begin
        alucont  = ALU_ADD;
        funct_ok = 1'b1;
        case (funct)
            F_ADD:   alucont = ALU_ADD;
            F_SUB:   alucont = ALU_SUB;
            F_AND:   alucont = ALU_AND;
            F_OR:    alucont = ALU_OR;
            F_SLT:   alucont = ALU_SLT;
            default: funct_ok = 1'b0;
        endcase
    end
endmodule

// File: rtl/mc_controller.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath controls, counts retired instructions and flags illegal ones.
module mc_controller
    import mc_controller_pkg::*;
#(
    parameter int unsigned CNT_W = 32
) (
    input  logic                clk,
    input  logic                reset,
    mc_controller_if.master     bus
);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;

    u3 rtype_alucont;
    u1 funct_ok;

    u1 pcen_c, memwrite_c, irwrite_c, regwrite_c, iord_c, alusrca_c;
    u1 memtoreg_c, regdst_c, illegal_c, retire_c;
    u2 alusrcb_c, pcsrc_c;
    u3 alucont_c;

    mc_aludec u_aludec (
        .funct    (bus.funct),
        .alucont  (rtype_alucont),
        .funct_ok (funct_ok)
    );

    always_comb begin
        state_d    = FETCH;
        pcen_c     = 1'b0;
        memwrite_c = 1'b0;
        irwrite_c  = 1'b0;
        regwrite_c = 1'b0;
        iord_c     = 1'b0;
        alusrca_c  = 1'b0;
        alusrcb_c  = 2'b00;
        memtoreg_c = 1'b0;
        regdst_c   = 1'b0;
        pcsrc_c    = 2'b00;
        alucont_c  = ALU_ADD;
        illegal_c  = 1'b0;
        retire_c   = 1'b0;

        case (state_q)
            FETCH: begin
                irwrite_c = 1'b1;
                alusrcb_c = 2'b01;
                pcsrc_c   = 2'b01;
                pcen_c    = 1'b1;
                state_d   = DECODE;
            end
            DECODE: begin
                alusrcb_c = 2'b11;
                case (bus.op)
                    OP_LW, OP_SW:     state_d = MEMADR;
                    OP_BEQ, OP_BNE:   state_d = BRANCH;
                    OP_ADDI, OP_SLTI: state_d = IMMEX;
                    OP_J:             state_d = JUMP;
                    OP_RTYPE: begin
                        if (funct_ok) state_d = EXECUTE;
                        else          illegal_c = 1'b1;
                    end
                    default:          illegal_c = 1'b1;
                endcase
            end
            MEMADR: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                state_d   = (bus.op == OP_LW) ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord_c  = 1'b1;
                state_d = MEMWB;
            end
            MEMWB: begin
                regwrite_c = 1'b1;
                memtoreg_c = 1'b1;
                retire_c   = 1'b1;
            end
            MEMWR: begin
                iord_c     = 1'b1;
                memwrite_c = 1'b1;
                retire_c   = 1'b1;
            end
            EXECUTE: begin
                alusrca_c = 1'b1;
                alucont_c = rtype_alucont;
                state_d   = ALUWB;
            end
            ALUWB: begin
                regwrite_c = 1'b1;
                regdst_c   = 1'b1;
                retire_c   = 1'b1;
            end
            IMMEX: begin
                alusrca_c = 1'b1;
                alusrcb_c = 2'b10;
                alucont_c = (bus.op == OP_SLTI) ? ALU_SLT : ALU_ADD;
                state_d   = IMMWB;
            end
            IMMWB: begin
                regwrite_c = 1'b1;
                retire_c   = 1'b1;
            end
            BRANCH: begin
                alusrca_c = 1'b1;
                alucont_c = ALU_SUB;
                pcen_c    = ((bus.op == OP_BEQ) &  bus.zero) |
                            ((bus.op == OP_BNE) & ~bus.zero);
                retire_c  = 1'b1;
            end
            JUMP: begin
                pcsrc_c  = 2'b10;
                pcen_c   = 1'b1;
                retire_c = 1'b1;
            end
            // Unused encodings recover to FETCH with every output held low.
            default: alucont_c = '0;
        endcase

        instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire_c};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    assign bus.pcen     = ~reset & pcen_c;
    assign bus.memwrite = ~reset & memwrite_c;
    assign bus.irwrite  = ~reset & irwrite_c;
    assign bus.regwrite = ~reset & regwrite_c;
    assign bus.iord     = ~reset & iord_c;
    assign bus.alusrca  = ~reset & alusrca_c;
    assign bus.memtoreg = ~reset & memtoreg_c;
    assign bus.regdst   = ~reset & regdst_c;
    assign bus.illegal  = ~reset & illegal_c;
    assign bus.alusrcb  = reset ? '0 : alusrcb_c;
    assign bus.pcsrc    = reset ? '0 : pcsrc_c;
    assign bus.alucont  = reset ? '0 : alucont_c;
    assign bus.state_o  = reset ? '0 : state_q;
    assign bus.instret  = reset ? '0 : instret_q;
endmodule

// File: tb/tb_mc_controller.sv
// Directed bench for mc_controller: walks each instruction class through its states.
module tb_mc_controller;
    import mc_controller_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   nvec = 0;
    int   nerr = 0;

    mc_controller_if #(.CNT_W(32)) bus ();

    mc_controller #(.CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    logic [15:0] ctl;
    assign ctl = {bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite, bus.iord,
                  bus.alusrca, bus.alusrcb, bus.memtoreg, bus.regdst,
                  bus.pcsrc, bus.alucont, bus.illegal};

    // Field order: pcen memwrite irwrite regwrite iord alusrca alusrcb memtoreg regdst pcsrc alucont illegal
    function automatic logic [15:0] cv(input logic pc, input logic mw, input logic ir,
                                       input logic rw, input logic io, input logic sa,
                                       input logic [1:0] sb, input logic mr, input logic rd,
                                       input logic [1:0] ps, input logic [2:0] ac,
                                       input logic il);
        return {pc, mw, ir, rw, io, sa, sb, mr, rd, ps, ac, il};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check state and control vector for the current cycle, then advance one clock.
    task automatic cyc(input string tag, input logic [3:0] st, input logic [15:0] c);
        #1;
        chk({tag, ".state"}, {28'd0, bus.state_o}, {28'd0, st});
        chk({tag, ".ctl"}, {16'd0, ctl}, {16'd0, c});
        tick();
    endtask

    logic [15:0] C_FETCH, C_DECODE, C_MEMADR, C_MEMRD, C_MEMWB, C_MEMWR, C_ALUWB, C_IMMWB, C_JUMP;

    initial begin
        C_FETCH  = cv(1,0,1,0,0,0,2'b01,0,0,2'b01,3'b010,0);
        C_DECODE = cv(0,0,0,0,0,0,2'b11,0,0,2'b00,3'b010,0);
        C_MEMADR = cv(0,0,0,0,0,1,2'b10,0,0,2'b00,3'b010,0);
        C_MEMRD  = cv(0,0,0,0,1,0,2'b00,0,0,2'b00,3'b010,0);
        C_MEMWB  = cv(0,0,0,1,0,0,2'b00,1,0,2'b00,3'b010,0);
        C_MEMWR  = cv(0,1,0,0,1,0,2'b00,0,0,2'b00,3'b010,0);
        C_ALUWB  = cv(0,0,0,1,0,0,2'b00,0,1,2'b00,3'b010,0);
        C_IMMWB  = cv(0,0,0,1,0,0,2'b00,0,0,2'b00,3'b010,0);
        C_JUMP   = cv(1,0,0,0,0,0,2'b00,0,0,2'b10,3'b010,0);

        reset     = 1'b1;
        bus.op    = 6'b100011;
        bus.funct = 6'b000000;
        bus.zero  = 1'b0;
        tick();
        tick();
        chk("rst.ctl", {16'd0, ctl}, 32'd0);
        chk("rst.state", {28'd0, bus.state_o}, 32'd0);
        chk("rst.instret", bus.instret, 32'd0);
        reset = 1'b0;

        // lw: 5 cycles
        cyc("lw.fetch", 4'd0, C_FETCH);
        cyc("lw.decode", 4'd1, C_DECODE);
        cyc("lw.memadr", 4'd2, C_MEMADR);
        cyc("lw.memrd", 4'd3, C_MEMRD);
        cyc("lw.memwb", 4'd4, C_MEMWB);
        #1 chk("lw.instret", bus.instret, 32'd1);

        // R-type sub
        bus.op = 6'b000000; bus.funct = 6'b100010;
        cyc("sub.fetch", 4'd0, C_FETCH);
        cyc("sub.decode", 4'd1, C_DECODE);
        cyc("sub.exec", 4'd6, cv(0,0,0,0,0,1,2'b00,0,0,2'b00,3'b110,0));
        cyc("sub.aluwb", 4'd7, C_ALUWB);
        #1 chk("sub.instret", bus.instret, 32'd2);

        // R-type slt
        bus.funct = 6'b101010;
        cyc("slt.fetch", 4'd0, C_FETCH);
        cyc("slt.decode", 4'd1, C_DECODE);
        cyc("slt.exec", 4'd6, cv(0,0,0,0,0,1,2'b00,0,0,2'b00,3'b111,0));
        cyc("slt.aluwb", 4'd7, C_ALUWB);
        #1 chk("slt.instret", bus.instret, 32'd3);

        // beq taken
        bus.op = 6'b000100; bus.funct = 6'b000000; bus.zero = 1'b1;
        cyc("beqt.fetch", 4'd0, C_FETCH);
        cyc("beqt.decode", 4'd1, C_DECODE);
        cyc("beqt.branch", 4'd10, cv(1,0,0,0,0,1,2'b00,0,0,2'b00,3'b110,0));
        #1 chk("beqt.instret", bus.instret, 32'd4);

        // beq not taken
        bus.zero = 1'b0;
        cyc("beqn.fetch", 4'd0, C_FETCH);
        cyc("beqn.decode", 4'd1, C_DECODE);
        cyc("beqn.branch", 4'd10, cv(0,0,0,0,0,1,2'b00,0,0,2'b00,3'b110,0));
        #1 chk("beqn.instret", bus.instret, 32'd5);

        // bne taken (zero=0)
        bus.op = 6'b000101;
        cyc("bne.fetch", 4'd0, C_FETCH);
        cyc("bne.decode", 4'd1, C_DECODE);
        cyc("bne.branch", 4'd10, cv(1,0,0,0,0,1,2'b00,0,0,2'b00,3'b110,0));
        #1 chk("bne.instret", bus.instret, 32'd6);

        // j
        bus.op = 6'b000010;
        cyc("j.fetch", 4'd0, C_FETCH);
        cyc("j.decode", 4'd1, C_DECODE);
        cyc("j.jump", 4'd11, C_JUMP);
        #1 chk("j.instret", bus.instret, 32'd7);

        // slti
        bus.op = 6'b001010;
        cyc("slti.fetch", 4'd0, C_FETCH);
        cyc("slti.decode", 4'd1, C_DECODE);
        cyc("slti.immex", 4'd8, cv(0,0,0,0,0,1,2'b10,0,0,2'b00,3'b111,0));
        cyc("slti.immwb", 4'd9, C_IMMWB);
        #1 chk("slti.instret", bus.instret, 32'd8);

        // illegal opcode
        bus.op = 6'b111111;
        cyc("ilop.fetch", 4'd0, C_FETCH);
        cyc("ilop.decode", 4'd1, cv(0,0,0,0,0,0,2'b11,0,0,2'b00,3'b010,1));
        cyc("ilop.next", 4'd0, C_FETCH);
        chk("ilop.instret", bus.instret, 32'd8);

        // illegal funct (already in DECODE after the fetch just checked)
        bus.op = 6'b000000; bus.funct = 6'b000111;
        cyc("ilfn.decode", 4'd1, cv(0,0,0,0,0,0,2'b11,0,0,2'b00,3'b010,1));
        cyc("ilfn.next", 4'd0, C_FETCH);
        chk("ilfn.instret", bus.instret, 32'd8);

        // reset during lw MEMRD (now in DECODE)
        bus.op = 6'b100011; bus.funct = 6'b000000;
        cyc("rlw.decode", 4'd1, C_DECODE);
        cyc("rlw.memadr", 4'd2, C_MEMADR);
        #1 chk("rlw.memrd", {28'd0, bus.state_o}, 32'd3);
        reset = 1'b1;
        #1;
        chk("rlw.rst.ctl", {16'd0, ctl}, 32'd0);
        chk("rlw.rst.state", {28'd0, bus.state_o}, 32'd0);
        chk("rlw.rst.instret", bus.instret, 32'd0);
        tick();
        reset = 1'b0;
        #1 chk("rlw.after.instret", bus.instret, 32'd0);

        // sw after reset
        bus.op = 6'b101011;
        cyc("sw.fetch", 4'd0, C_FETCH);
        cyc("sw.decode", 4'd1, C_DECODE);
        cyc("sw.memadr", 4'd2, C_MEMADR);
        cyc("sw.memwr", 4'd5, C_MEMWR);
        cyc("sw.next", 4'd0, C_FETCH);
        chk("sw.instret", bus.instret, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
